// File: rtl/warp_dispatch_if.sv
// warp_dispatch_if: groups the warp-table read port and the fetch-side dispatch handshake.
//   master : used by warp_dispatch (drives wt_read_en and the disp_* outputs)
//   slave  : used by the environment (warp_table responder and fetch stage)
// Signals
//   wt_read_en    pop request to warp_table
//   wt_read_data  entry returned by warp_table {pc, mask, wid}
//   wt_read_valid wt_read_data valid this cycle
//   wt_fifo_empty warp_table holds no entries
//   disp_valid    dispatch entry available
//   disp_ready    fetch stage accepts entry
//   disp_pc/disp_mask/disp_wid  head entry fields
interface warp_dispatch_if #(
   parameter int unsigned PC_W   = 32,
   parameter int unsigned MASK_W = 8,
   parameter int unsigned WID_W  = 4
);
   localparam int unsigned DATA_W = PC_W + MASK_W + WID_W;

   logic              wt_read_en;
   logic [DATA_W-1:0] wt_read_data;
   logic              wt_read_valid;
   logic              wt_fifo_empty;
   logic              disp_valid;
   logic              disp_ready;
   logic [PC_W-1:0]   disp_pc;
   logic [MASK_W-1:0] disp_mask;
   logic [WID_W-1:0]  disp_wid;

   modport master (
      output wt_read_en,
      input  wt_read_data,
      input  wt_read_valid,
      input  wt_fifo_empty,
      output disp_valid,
      input  disp_ready,
      output disp_pc,
      output disp_mask,
      output disp_wid
   );

   modport slave (
      input  wt_read_en,
      output wt_read_data,
      output wt_read_valid,
      output wt_fifo_empty,
      input  disp_valid,
      output disp_ready,
      input  disp_pc,
      input  disp_mask,
      input  disp_wid
   );
endinterface

// File: rtl/warp_dispatch.sv
// warp_dispatch: consumer end of the warp table. Pops entries (one read outstanding at most),
// drops entries with an all-zero thread mask, buffers the rest in an in-order skid queue and
// presents the head to fetch on a valid/ready handshake. flush drops buffered and in-flight
// entries.
// Ports
//   clk, rst   clock and synchronous active-high reset
//   bus        warp_dispatch_if.master: warp-table read port + dispatch handshake
//   flush      drop queue contents and any in-flight response
//   proto_err  sticky: wt_read_valid seen with no read outstanding (cleared by rst only)
// Optional feature (macro WARP_DISPATCH_STATS_EN):
//   disp_count   saturating count of dispatched entries
//   stall_count  saturating count of disp_valid & ~disp_ready cycles
module warp_dispatch #(
   parameter int unsigned DATA_W    = 44,
   parameter int unsigned PC_W      = 32,
   parameter int unsigned MASK_W    = 8,
   parameter int unsigned WID_W     = 4,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic           clk,
   input  logic           rst,
   warp_dispatch_if.master bus,
   input  logic           flush,
   output logic           proto_err
`ifdef WARP_DISPATCH_STATS_EN
   ,
   output logic [31:0]    disp_count,
   output logic [31:0]    stall_count
`endif
);
   localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   typedef enum logic [1:0] {StIdle, StWaitRsp, StDiscard} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] mem_q [BUF_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]  occ_q, occ_d, occ_upd;
   logic              proto_err_q, proto_err_d;
   logic              disp_valid, enq, pop, pending, rd_en;
   logic [OCC_W:0]    occ_ahead;
   logic [DATA_W-1:0] head;

   assign disp_valid = (occ_q != '0);
   assign pending    = (state_q == StWaitRsp) & ~bus.wt_read_valid;
   // Zero-mask entries carry no active threads and are never queued.
   assign enq = (state_q == StWaitRsp) & bus.wt_read_valid & ~flush &
                (bus.wt_read_data[WID_W +: MASK_W] != '0);
   assign pop = disp_valid & bus.disp_ready & ~flush;

   // Occupancy after this edge; the response landing this cycle is counted so a
   // back-to-back read can never find the queue full when its data returns.
   assign occ_upd   = occ_q + OCC_W'(enq) - OCC_W'(pop);
   assign occ_ahead = {1'b0, occ_upd} + (OCC_W+1)'(pending);

   assign rd_en = ~rst & ~flush & ~bus.wt_fifo_empty &
                  ((state_q == StIdle) | ((state_q == StWaitRsp) & bus.wt_read_valid)) &
                  (occ_ahead < (OCC_W+1)'(BUF_DEPTH));

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (rd_en) state_d = StWaitRsp;
         end
         StWaitRsp: begin
            if (bus.wt_read_valid) state_d = rd_en ? StWaitRsp : StIdle;
            else if (flush)        state_d = StDiscard;
         end
         StDiscard: begin
            if (bus.wt_read_valid) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      occ_d       = occ_upd;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      proto_err_d = proto_err_q | ((state_q == StIdle) & bus.wt_read_valid);
      if (flush) begin
         occ_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         occ_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         proto_err_q <= 1'b0;
         for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         occ_q       <= occ_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         proto_err_q <= proto_err_d;
         if (enq) mem_q[wr_ptr_q] <= bus.wt_read_data;
      end
   end

   assign head           = mem_q[rd_ptr_q];
   assign bus.wt_read_en = rd_en;
   assign bus.disp_valid = disp_valid;
   assign bus.disp_pc    = head[DATA_W-1 -: PC_W];
   assign bus.disp_mask  = head[WID_W +: MASK_W];
   assign bus.disp_wid   = head[WID_W-1:0];
   assign proto_err      = proto_err_q;

`ifdef WARP_DISPATCH_STATS_EN
   logic [31:0] disp_count_q, stall_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         disp_count_q  <= '0;
         stall_count_q <= '0;
      end else begin
         if (pop && disp_count_q != '1) disp_count_q <= disp_count_q + 32'd1;
         if (disp_valid && !bus.disp_ready && stall_count_q != '1)
            stall_count_q <= stall_count_q + 32'd1;
      end
   end

   assign disp_count  = disp_count_q;
   assign stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_warp_dispatch.sv
// tb_warp_dispatch: directed bench for warp_dispatch. A cycle table covers reset, single
// dispatch latency, zero-mask drop and the stray-response error; hand sequences with a small
// warp-table responder and an expected-order queue cover back-pressure, flush and counters.
module tb_warp_dispatch;
   logic clk, rst, flush, proto_err;
`ifdef WARP_DISPATCH_STATS_EN
   logic [31:0] disp_count, stall_count;
`endif

   warp_dispatch_if bus ();

   warp_dispatch dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .flush     (flush),
      .proto_err (proto_err)
`ifdef WARP_DISPATCH_STATS_EN
      ,
      .disp_count  (disp_count),
      .stall_count (stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   typedef struct {
      logic        r, vld;
      logic [43:0] data;
      logic        empty, fl, rdy;
      logic        en, dv;
      logic [43:0] ex;
      logic        perr;
   } vec_t;

   function automatic vec_t mkv(input logic r, input logic vld, input logic [43:0] data,
                                input logic empty, input logic fl, input logic rdy,
                                input logic en, input logic dv, input logic [43:0] ex,
                                input logic perr);
      vec_t v;
      v.r = r; v.vld = vld; v.data = data; v.empty = empty; v.fl = fl; v.rdy = rdy;
      v.en = en; v.dv = dv; v.ex = ex; v.perr = perr;
      return v;
   endfunction

   function automatic logic [43:0] ent(input logic [31:0] pc, input logic [7:0] m,
                                       input logic [3:0] w);
      return {pc, m, w};
   endfunction

   // Warp-table responder and scoreboard state
   logic [43:0] wt_q[$];
   logic [43:0] exp_q[$];
   logic [43:0] pend;
   int          rsp_cnt = 0;
   int          rsp_dly = 1;
   int          popped = 0;
   int          stall_seen = 0;
   logic        s_en, s_dv;
   logic [43:0] s_head;

   task automatic push(input logic [43:0] e, input bit expect_out);
      wt_q.push_back(e);
      if (expect_out) exp_q.push_back(e);
      bus.wt_fifo_empty = 1'b0;
   endtask

   // One clock: sample at negedge, then advance the responder just after posedge.
   task automatic tick();
      logic [43:0] e;
      @(negedge clk);
      s_en   = bus.wt_read_en;
      s_dv   = bus.disp_valid;
      s_head = {bus.disp_pc, bus.disp_mask, bus.disp_wid};
      if (s_dv && !bus.disp_ready) stall_seen++;
      if (s_dv && bus.disp_ready && !flush && !rst) begin
         popped++;
         if (exp_q.size() == 0) chk("unexpected dispatch", s_head, 44'h0);
         else begin
            e = exp_q.pop_front();
            chk("dispatch order", s_head, e);
         end
      end
      @(posedge clk);
      #1;
      bus.wt_read_valid = 1'b0;
      bus.wt_read_data  = '0;
      if (s_en) begin
         if (wt_q.size() == 0) chk("read_en with table empty", 1, 0);
         else pend = wt_q.pop_front();
         rsp_cnt = rsp_dly;
      end
      if (rsp_cnt > 0) begin
         rsp_cnt--;
         if (rsp_cnt == 0) begin
            bus.wt_read_valid = 1'b1;
            bus.wt_read_data  = pend;
         end
      end
      bus.wt_fifo_empty = (wt_q.size() == 0);
   endtask

   task automatic drain(input string name, input int bound);
      int k = 0;
      while (exp_q.size() != 0 && k < bound) begin
         tick();
         k++;
      end
      chk(name, exp_q.size(), 0);
   endtask

   vec_t vecs[15];

   initial begin
      logic [43:0] e0;
      int          p0;

      vecs[0]  = mkv(1, 0, 44'h0,           1, 0, 1, 0, 0, 44'h0,           0);
      vecs[1]  = mkv(0, 0, 44'h0,           0, 0, 1, 1, 0, 44'h0,           0);
      vecs[2]  = mkv(0, 1, 44'hABCDE0123F5, 1, 0, 1, 0, 0, 44'h0,           0);
      vecs[3]  = mkv(0, 0, 44'h0,           1, 0, 1, 0, 1, 44'hABCDE0123F5, 0);
      vecs[4]  = mkv(0, 0, 44'h0,           0, 0, 1, 1, 0, 44'h0,           0);
      vecs[5]  = mkv(0, 1, 44'h111111110F1, 0, 0, 1, 1, 0, 44'h0,           0);
      vecs[6]  = mkv(0, 1, 44'h22222222002, 0, 0, 1, 1, 1, 44'h111111110F1, 0);
      vecs[7]  = mkv(0, 1, 44'h33333333F03, 1, 0, 1, 0, 0, 44'h0,           0);
      vecs[8]  = mkv(0, 0, 44'h0,           1, 0, 1, 0, 1, 44'h33333333F03, 0);
      vecs[9]  = mkv(0, 0, 44'h0,           1, 0, 1, 0, 0, 44'h0,           0);
      vecs[10] = mkv(0, 1, 44'h55555555FF7, 1, 0, 1, 0, 0, 44'h0,           0);
      vecs[11] = mkv(0, 0, 44'h0,           1, 0, 1, 0, 0, 44'h0,           1);
      vecs[12] = mkv(0, 0, 44'h0,           1, 0, 1, 0, 0, 44'h0,           1);
      vecs[13] = mkv(1, 0, 44'h0,           1, 0, 1, 0, 0, 44'h0,           1);
      vecs[14] = mkv(0, 0, 44'h0,           1, 0, 1, 0, 0, 44'h0,           0);

      rst = 1'b1; flush = 1'b0;
      bus.wt_read_valid = 1'b0; bus.wt_read_data = '0;
      bus.wt_fifo_empty = 1'b1; bus.disp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Cycle table: dispatch latency, zero-mask drop, stray response, rst clears error
      for (int i = 0; i < 15; i++) begin
         rst               = vecs[i].r;
         bus.wt_read_valid = vecs[i].vld;
         bus.wt_read_data  = vecs[i].data;
         bus.wt_fifo_empty = vecs[i].empty;
         flush             = vecs[i].fl;
         bus.disp_ready    = vecs[i].rdy;
         @(negedge clk);
         chk($sformatf("v%0d wt_read_en", i), bus.wt_read_en, vecs[i].en);
         chk($sformatf("v%0d disp_valid", i), bus.disp_valid, vecs[i].dv);
         chk($sformatf("v%0d proto_err", i), proto_err, vecs[i].perr);
         if (vecs[i].dv) begin
            e0 = vecs[i].ex;
            chk($sformatf("v%0d disp_pc", i), bus.disp_pc, e0[43:12]);
            chk($sformatf("v%0d disp_mask", i), bus.disp_mask, e0[11:4]);
            chk($sformatf("v%0d disp_wid", i), bus.disp_wid, e0[3:0]);
         end
         @(posedge clk);
         #1;
      end
      rst = 1'b0; bus.wt_read_valid = 1'b0; bus.wt_read_data = '0;
      bus.wt_fifo_empty = 1'b1;

      // Back-pressure: six entries with ready low, only two may be pulled
      bus.disp_ready = 1'b0;
      rsp_dly = 1;
      for (int i = 0; i < 6; i++)
         push(ent(32'h1000_0000 + 32'(i * 4), 8'h01 << i, 4'(i + 8)), 1'b1);
      e0 = exp_q[0];
      repeat (8) tick();
      chk("bp read_en low when full", s_en, 0);
      chk("bp disp_valid", s_dv, 1);
      chk("bp head held", s_head, e0);
      chk("bp entries left in table", wt_q.size(), 4);
      p0 = popped;
      bus.disp_ready = 1'b1;
      drain("bp drain", 60);
      chk("bp dispatched count", popped - p0, 6);
      chk("bp table emptied", wt_q.size(), 0);

      // Flush while a read is outstanding; delayed response must be dropped
      repeat (2) tick();
      rsp_dly = 3;
      push(ent(32'hDEAD_BEEF, 8'hFF, 4'hE), 1'b0);
      push(ent(32'hCAFE_0000, 8'h81, 4'h6), 1'b1);
      tick();
      chk("fl read issued", s_en, 1);
      rsp_dly = 1;
      flush = 1'b1;
      tick();
      chk("fl read_en low in flush", s_en, 0);
      flush = 1'b0;
      tick();
      chk("fl read_en low in discard", s_en, 0);
      chk("fl disp_valid low in discard", s_dv, 0);
      tick();
      chk("fl no read on dropped rsp", s_en, 0);
      tick();
      chk("fl next read issued", s_en, 1);
      chk("fl dropped rsp not queued", s_dv, 0);
      tick();
      chk("fl disp_valid before next rsp", s_dv, 0);
      drain("fl next entry dispatched", 10);

      // Flush clears buffered entries
      bus.disp_ready = 1'b0;
      push(ent(32'h0BAD_0001, 8'h0C, 4'h1), 1'b0);
      push(ent(32'h0BAD_0002, 8'h30, 4'h2), 1'b0);
      repeat (5) tick();
      chk("qf buffered before flush", s_dv, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      chk("qf disp_valid after flush", s_dv, 0);
      bus.disp_ready = 1'b1;
      tick();
      chk("qf queue stays empty", s_dv, 0);
      chk("qf proto_err clear", proto_err, 0);

`ifdef WARP_DISPATCH_STATS_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("st disp_count reset", disp_count, 0);
      chk("st stall_count reset", stall_count, 0);
      bus.disp_ready = 1'b0;
      stall_seen = 0;
      for (int i = 0; i < 4; i++) push(ent(32'h7000_0000 + 32'(i), 8'hA5, 4'(i)), 1'b1);
      for (int k = 0; k < 20 && stall_seen < 3; k++) tick();
      chk("st stalls reached", stall_seen, 3);
      bus.disp_ready = 1'b1;
      drain("st drain", 40);
      chk("st disp_count", disp_count, 4);
      chk("st stall_count", stall_count, 3);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      chk("st disp_count after flush", disp_count, 4);
      chk("st stall_count after flush", stall_count, 3);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
